// File: rtl/tdm_demux_pkg.sv
// Shared definitions for the TDM demux: FSM state encoding used by the demux
// and by future mux-side TDM blocks.
package tdm_demux_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/decoder_onehot.sv
// Binary-to-one-hot decoder: bit k of onehot is set when sel equals k.
// Codes at or above CHANNELS decode to all zeros.
module decoder_onehot #(
   parameter int SEL_W    = 2,
   parameter int CHANNELS = 4
) (
   input  logic [SEL_W-1:0]    sel,
   output logic [CHANNELS-1:0] onehot
);

   always_comb begin
      onehot = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (sel == SEL_W'(k)) onehot[k] = 1'b1;
      end
   end

endmodule

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: frame_sync marks channel 0, later beats fill the
// channels round-robin, and short or unsynchronised frames raise sync_err.
module tdm_demux
   import tdm_demux_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [WIDTH-1:0]          in_data,
   input  logic                      in_valid,
   input  logic                      frame_sync,
   output logic [CHANNELS*WIDTH-1:0] out_data,
   output logic [CHANNELS-1:0]       out_valid,
   output logic [SEL_W-1:0]          channel,
   output logic                      frame_done,
   output logic                      sync_err,
   output logic                      busy,
   output state_t                    state
);

   // Input handshake: a beat is any cycle with in_valid=1; there is no ready,
   // every beat is consumed the cycle it is presented (written or dropped).

   localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

   logic [SEL_W-1:0]    wr_sel;
   logic [CHANNELS-1:0] sel_onehot;
   logic [CHANNELS-1:0] wr_en;
   logic                accept;

   // A sync beat always restarts at channel 0; otherwise only a running,
   // mid-frame pointer accepts the beat.
   assign wr_sel = frame_sync ? '0 : channel;
   assign accept = in_valid && (frame_sync || (state == ST_RUN && channel != '0));
   assign wr_en  = sel_onehot & {CHANNELS{accept}};
   assign busy   = (state == ST_RUN);

   decoder_onehot #(
      .SEL_W    (SEL_W),
      .CHANNELS (CHANNELS)
   ) u_decoder (
      .sel    (wr_sel),
      .onehot (sel_onehot)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_data   <= '0;
         out_valid  <= '0;
         channel    <= '0;
         frame_done <= 1'b0;
         sync_err   <= 1'b0;
         state      <= ST_IDLE;
      end else begin
         out_valid  <= wr_en;
         frame_done <= 1'b0;
         sync_err   <= 1'b0;
         for (int k = 0; k < CHANNELS; k++) begin
            if (wr_en[k]) out_data[k*WIDTH +: WIDTH] <= in_data;
         end
         if (in_valid) begin
            case (state)
               ST_IDLE: begin
                  if (frame_sync) begin
                     channel <= SEL_W'(1);
                     state   <= ST_RUN;
                  end
               end
               ST_RUN: begin
                  if (frame_sync) begin
                     // Sync arriving mid-frame abandons the partial frame.
                     sync_err <= (channel != '0);
                     channel  <= SEL_W'(1);
                  end else if (channel == '0) begin
                     sync_err <= 1'b1;
                     state    <= ST_IDLE;
                  end else if (channel == LAST_CH) begin
                     frame_done <= 1'b1;
                     channel    <= '0;
                  end else begin
                     channel <= channel + SEL_W'(1);
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux: a 4-channel instance for most scenarios and a
// 3-channel instance for the non-power-of-two wrap.
module tb_tdm_demux;
   import tdm_demux_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  in_data = '0;
   logic        in_valid = 1'b0;
   logic        frame_sync = 1'b0;

   logic [31:0] out_data;
   logic [3:0]  out_valid;
   logic [1:0]  channel;
   logic        frame_done, sync_err, busy;
   state_t      state;

   logic [23:0] out_data3;
   logic [2:0]  out_valid3;
   logic [1:0]  channel3;
   logic        frame_done3, sync_err3, busy3;
   state_t      state3;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   tdm_demux #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .frame_sync(frame_sync), .out_data(out_data), .out_valid(out_valid),
      .channel(channel), .frame_done(frame_done), .sync_err(sync_err),
      .busy(busy), .state(state)
   );

   tdm_demux #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) dut3 (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .frame_sync(frame_sync), .out_data(out_data3), .out_valid(out_valid3),
      .channel(channel3), .frame_done(frame_done3), .sync_err(sync_err3),
      .busy(busy3), .state(state3)
   );

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; in_valid = 1'b0; frame_sync = 1'b0; in_data = '0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Present one cycle of input, then return 1 ns after the capturing edge.
   task automatic step(input logic v, input logic s, input logic [7:0] d);
      @(negedge clk);
      in_valid = v; frame_sync = s; in_data = d;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (busy !== 1'b0 || state !== ST_IDLE || channel !== 2'd0) begin
         n_fail++; $display("FAIL reset_idle: busy=%b state=%b ch=%0d, need 0/0/0", busy, state, channel);
      end
      step(1, 1, 8'hA5);
      step(1, 0, 8'h5A);
      n_checks++;
      if (out_valid !== 4'b0010 || channel !== 2'd2 || busy !== 1'b1) begin
         n_fail++; $display("FAIL reset_pre: ov=%b ch=%0d busy=%b, need 0010/2/1", out_valid, channel, busy);
      end
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if (out_data !== 32'h0 || out_valid !== 4'b0 || channel !== 2'd0 || frame_done !== 1'b0 ||
          sync_err !== 1'b0 || busy !== 1'b0 || state !== ST_IDLE) begin
         n_fail++; $display("FAIL reset_async: data=%h ov=%b ch=%0d fd=%b se=%b busy=%b, need all 0",
                            out_data, out_valid, channel, frame_done, sync_err, busy);
      end
      in_valid = 1'b0; frame_sync = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_frame();
      logic [7:0] d [4]    = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      logic [3:0] ov_e [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      logic [1:0] ch_e [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         step(1, (i == 0), d[i]);
         n_checks++;
         if (out_valid !== ov_e[i] || frame_done !== (i == 3) || sync_err !== 1'b0 || channel !== ch_e[i]) begin
            n_fail++; $display("FAIL frame_beat%0d: ov=%b fd=%b se=%b ch=%0d, need %b/%b/0/%0d",
                               i, out_valid, frame_done, sync_err, channel, ov_e[i], (i == 3), ch_e[i]);
         end
      end
      n_checks++;
      if (out_data !== 32'hD4C3B2A1) begin
         n_fail++; $display("FAIL frame_data: got %h need d4c3b2a1", out_data);
      end
      step(0, 0, 8'h00);
      n_checks++;
      if (out_valid !== 4'b0 || frame_done !== 1'b0 || busy !== 1'b1 || out_data !== 32'hD4C3B2A1) begin
         n_fail++; $display("FAIL frame_idle: ov=%b fd=%b busy=%b data=%h", out_valid, frame_done, busy, out_data);
      end
   endtask

   task automatic test_short_frame();
      do_reset();
      step(1, 1, 8'h11);
      step(1, 0, 8'h22);
      step(1, 1, 8'h33);
      n_checks++;
      if (sync_err !== 1'b1 || frame_done !== 1'b0 || out_valid !== 4'b0001 || channel !== 2'd1) begin
         n_fail++; $display("FAIL short_flags: se=%b fd=%b ov=%b ch=%0d, need 1/0/0001/1",
                            sync_err, frame_done, out_valid, channel);
      end
      n_checks++;
      if (out_data[15:0] !== 16'h2233 || busy !== 1'b1) begin
         n_fail++; $display("FAIL short_data: ch1ch0=%h busy=%b, need 2233/1", out_data[15:0], busy);
      end
      step(0, 0, 8'h00);
      n_checks++;
      if (sync_err !== 1'b0) begin
         n_fail++; $display("FAIL short_pulse: se=%b need 0", sync_err);
      end
   endtask

   task automatic test_missing_sync();
      do_reset();
      for (int i = 0; i < 4; i++) step(1, (i == 0), 8'(i + 1));
      step(1, 0, 8'h55);
      n_checks++;
      if (sync_err !== 1'b1 || out_valid !== 4'b0 || busy !== 1'b0 || channel !== 2'd0 ||
          out_data !== 32'h04030201) begin
         n_fail++; $display("FAIL missing_sync: se=%b ov=%b busy=%b ch=%0d data=%h, need 1/0/0/0/04030201",
                            sync_err, out_valid, busy, channel, out_data);
      end
      step(1, 0, 8'h66);
      n_checks++;
      if (sync_err !== 1'b0 || out_valid !== 4'b0 || busy !== 1'b0 || out_data !== 32'h04030201) begin
         n_fail++; $display("FAIL idle_drop: se=%b ov=%b busy=%b data=%h, need 0/0/0/04030201",
                            sync_err, out_valid, busy, out_data);
      end
   endtask

   task automatic test_gaps();
      logic [7:0] d [4]   = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      int         gap [4] = '{0, 3, 1, 2};
      logic [1:0] ch_before [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         for (int g = 0; g < gap[i]; g++) begin
            step(0, 1, 8'hFF);
            n_checks++;
            if (channel !== ch_before[i] || out_valid !== 4'b0 || frame_done !== 1'b0) begin
               n_fail++; $display("FAIL gap_hold%0d: ch=%0d ov=%b fd=%b, need %0d/0/0",
                                  i, channel, out_valid, frame_done, ch_before[i]);
            end
         end
         step(1, (i == 0), d[i]);
      end
      n_checks++;
      if (out_data !== 32'hD4C3B2A1 || frame_done !== 1'b1 || channel !== 2'd0) begin
         n_fail++; $display("FAIL gap_data: data=%h fd=%b ch=%0d, need d4c3b2a1/1/0", out_data, frame_done, channel);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] d [6]    = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
      logic [1:0] ch_e [6] = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
      logic [2:0] ov_e [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      int done_cnt = 0;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step(1, (i == 0 || i == 3), d[i]);
         if (frame_done3) done_cnt++;
         n_checks++;
         if (channel3 !== ch_e[i] || out_valid3 !== ov_e[i] || sync_err3 !== 1'b0 ||
             frame_done3 !== (i == 2 || i == 5)) begin
            n_fail++; $display("FAIL b2b_beat%0d: ch=%0d ov=%b se=%b fd=%b, need %0d/%b/0/%b",
                               i, channel3, out_valid3, sync_err3, frame_done3, ch_e[i], ov_e[i], (i == 2 || i == 5));
         end
      end
      n_checks++;
      if (out_data3 !== 24'h605040 || done_cnt != 2 || busy3 !== 1'b1) begin
         n_fail++; $display("FAIL b2b_total: data=%h done=%0d busy=%b, need 605040/2/1", out_data3, done_cnt, busy3);
      end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_short_frame();
      test_missing_sync();
      test_gaps();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
